// File: rtl/tuning_code_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : tuning_code_engine_if
//  Purpose  : Request / bend / result bundle between the voice allocator
//             (master) and the tuning code engine (slave).
//  Signals  : i_req, i_voice, i_note   note request (accepted on i_req & o_ready)
//             i_bend_we, i_bend        pitch-bend write strobe and value
//             o_ready                  engine idle, request may be accepted
//             o_valid, o_sweep         result strobe, sweep qualifier
//             o_voice, o_code          result voice and phase increment
//  Revision : 1.0  initial release
// ============================================================================
interface tuning_code_engine_if #(
    parameter int VOICE_W = 3,
    parameter int CODE_W  = 32
);
    logic                i_req;
    logic [VOICE_W-1:0]  i_voice;
    logic [6:0]          i_note;
    logic                i_bend_we;
    logic [13:0]         i_bend;
    logic                o_ready;
    logic                o_valid;
    logic                o_sweep;
    logic [VOICE_W-1:0]  o_voice;
    logic [CODE_W-1:0]   o_code;

    modport master (
        output i_req, i_voice, i_note, i_bend_we, i_bend,
        input  o_ready, o_valid, o_sweep, o_voice, o_code
    );

    modport slave (
        input  i_req, i_voice, i_note, i_bend_we, i_bend,
        output o_ready, o_valid, o_sweep, o_voice, o_code
    );
endinterface
`default_nettype wire

// File: rtl/tuning_code_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tuning_code_engine
//  Purpose  : Converts MIDI note + global pitch bend into a DDS phase
//             increment per voice. Uses a 12-entry top-octave table shifted
//             down by octave, stores each voice's note, and re-tunes every
//             voice when the bend changes.
//  Ports    : i_clk    system clock
//             i_rst_n  asynchronous reset, active low
//             bus      tuning_code_engine_if.slave (request/bend in, code out)
//  Revision : 1.0  initial release
// ============================================================================
module tuning_code_engine #(
    parameter int CODE_W       = 32,
    parameter int N_VOICES     = 8,
    parameter int VOICE_W      = 3,
    parameter int BEND_SHIFT   = 16,
    parameter int DEFAULT_NOTE = 78
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    tuning_code_engine_if.slave  bus
);
    localparam int PROD_W = CODE_W + 15;
    localparam int SUM_W  = CODE_W + 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DIV  = 3'd1;
    localparam logic [2:0] S_LOOK = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    // Phase increments for C9..B9 at 48 MHz with a 32-bit accumulator
    function automatic logic [20:0] top_octave(input logic [3:0] s);
        case (s)
            4'd0:    top_octave = 21'd749115;
            4'd1:    top_octave = 21'd793660;
            4'd2:    top_octave = 21'd840854;
            4'd3:    top_octave = 21'd890853;
            4'd4:    top_octave = 21'd943826;
            4'd5:    top_octave = 21'd999949;
            4'd6:    top_octave = 21'd1059409;
            4'd7:    top_octave = 21'd1122405;
            4'd8:    top_octave = 21'd1189147;
            4'd9:    top_octave = 21'd1259857;
            4'd10:   top_octave = 21'd1334772;
            4'd11:   top_octave = 21'd1414142;
            default: top_octave = 21'd0;
        endcase
    endfunction

    logic [2:0]          state_q,   state_d;
    logic [6:0]          rem_q,     rem_d;
    logic [3:0]          oct_q,     oct_d;
    logic [VOICE_W-1:0]  voice_q,   voice_d;
    logic                sweep_q,   sweep_d;
    logic [13:0]         bend_q,    bend_d;
    logic                pending_q, pending_d;
    logic [CODE_W-1:0]   base_q,    base_d;
    logic                o_valid_q, o_valid_d;
    logic                o_sweep_q, o_sweep_d;
    logic [VOICE_W-1:0]  o_voice_q, o_voice_d;
    logic [CODE_W-1:0]   o_code_q,  o_code_d;
    logic [6:0]          notes_q [N_VOICES];

    logic                       w_pending_clr;
    logic                       w_note_we;
    logic                       w_last_voice;
    logic [VOICE_W-1:0]         w_voice_nxt;
    logic [CODE_W-1:0]          w_tbl;
    logic signed [13:0]         w_bs;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [PROD_W-1:0]   w_scaled;
    logic signed [SUM_W-1:0]    w_sum;
    logic [CODE_W-1:0]          w_code;

    assign w_tbl        = CODE_W'(top_octave(rem_q[3:0]));
    assign w_voice_nxt  = voice_q + 1'b1;
    assign w_last_voice = (int'(voice_q) == N_VOICES - 1);
    assign w_note_we    = (state_q == S_IDLE) && bus.i_req && (int'(bus.i_voice) < N_VOICES);

    // Flipping the MSB of the offset-binary bend gives bend-8192 in two's complement
    assign w_bs     = $signed({~bend_q[13], bend_q[12:0]});
    assign w_prod   = PROD_W'($signed({1'b0, base_q})) * PROD_W'(w_bs);
    assign w_scaled = w_prod >>> BEND_SHIFT;
    assign w_sum    = SUM_W'(w_scaled) + SUM_W'($signed({1'b0, base_q}));

    always_comb begin
        w_code = w_sum[CODE_W-1:0];
        if (w_sum[SUM_W-1]) begin
            w_code = '0;
        end else if (|w_sum[SUM_W-2:CODE_W]) begin
            w_code = '1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        oct_d         = oct_q;
        voice_d       = voice_q;
        sweep_d       = sweep_q;
        base_d        = base_q;
        o_valid_d     = 1'b0;
        o_sweep_d     = o_sweep_q;
        o_voice_d     = o_voice_q;
        o_code_d      = o_code_q;
        w_pending_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A request takes priority; a pending sweep waits for the next idle cycle
                if (bus.i_req) begin
                    voice_d = bus.i_voice;
                    rem_d   = bus.i_note;
                    oct_d   = 4'd0;
                    sweep_d = 1'b0;
                    state_d = S_DIV;
                end else if (pending_q) begin
                    w_pending_clr = 1'b1;
                    voice_d       = '0;
                    rem_d         = notes_q[0];
                    oct_d         = 4'd0;
                    sweep_d       = 1'b1;
                    state_d       = S_DIV;
                end
            end
            S_DIV: begin
                if (rem_q >= 7'd12) begin
                    rem_d = rem_q - 7'd12;
                    oct_d = oct_q + 4'd1;
                end else begin
                    state_d = S_LOOK;
                end
            end
            S_LOOK: begin
                base_d  = w_tbl >> (4'd10 - oct_q);
                state_d = S_MUL;
            end
            S_MUL: begin
                o_code_d  = w_code;
                o_voice_d = voice_q;
                o_sweep_d = sweep_q;
                o_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (sweep_q && !w_last_voice) begin
                    voice_d = w_voice_nxt;
                    rem_d   = notes_q[w_voice_nxt];
                    oct_d   = 4'd0;
                    state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A bend write always re-arms the sweep, even in the cycle a sweep starts
    assign pending_d = bus.i_bend_we ? 1'b1 : (w_pending_clr ? 1'b0 : pending_q);
    assign bend_d    = bus.i_bend_we ? bus.i_bend : bend_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            oct_q     <= '0;
            voice_q   <= '0;
            sweep_q   <= 1'b0;
            bend_q    <= 14'd8192;
            pending_q <= 1'b0;
            base_q    <= '0;
            o_valid_q <= 1'b0;
            o_sweep_q <= 1'b0;
            o_voice_q <= '0;
            o_code_q  <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                notes_q[i] <= 7'(DEFAULT_NOTE);
            end
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            oct_q     <= oct_d;
            voice_q   <= voice_d;
            sweep_q   <= sweep_d;
            bend_q    <= bend_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            o_valid_q <= o_valid_d;
            o_sweep_q <= o_sweep_d;
            o_voice_q <= o_voice_d;
            o_code_q  <= o_code_d;
            if (w_note_we) begin
                notes_q[bus.i_voice] <= bus.i_note;
            end
        end
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_valid = o_valid_q;
    assign bus.o_sweep = o_sweep_q;
    assign bus.o_voice = o_voice_q;
    assign bus.o_code  = o_code_q;
endmodule
`default_nettype wire

// File: tb/tb_tuning_code_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tuning_code_engine
//  Purpose  : Self-checking bench for tuning_code_engine (4 voices). Expected
//             results are pushed to a scoreboard queue when stimulus is driven
//             and compared against each o_valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tuning_code_engine;
    localparam int N_V = 4;
    localparam int V_W = 2;

    typedef struct {
        int     voice;
        longint code;
        int     sweep;
    } exp_t;

    logic   clk;
    logic   rst_n;
    int     checks;
    int     failures;
    exp_t   sb[$];
    exp_t   mon_e;
    int     m_notes[N_V];
    int     m_bend;

    tuning_code_engine_if #(.VOICE_W(V_W), .CODE_W(32)) bus ();

    tuning_code_engine #(
        .CODE_W(32), .N_VOICES(N_V), .VOICE_W(V_W), .BEND_SHIFT(16), .DEFAULT_NOTE(78)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint tone(input int s);
        case (s)
            0: tone = 749115;   1: tone = 793660;   2: tone = 840854;
            3: tone = 890853;   4: tone = 943826;   5: tone = 999949;
            6: tone = 1059409;  7: tone = 1122405;  8: tone = 1189147;
            9: tone = 1259857;  10: tone = 1334772; default: tone = 1414142;
        endcase
    endfunction

    function automatic longint model_code(input int note, input int bend);
        longint base;
        longint code;
        base = tone(note % 12) >> (10 - note / 12);
        code = base + ((base * longint'(bend - 8192)) >>> 16);
        if (code < 0) code = 0;
        if (code > 64'h0000_0000_FFFF_FFFF) code = 64'h0000_0000_FFFF_FFFF;
        return code;
    endfunction

    function automatic void push_sweep();
        for (int v = 0; v < N_V; v++) begin
            sb.push_back('{voice: v, code: model_code(m_notes[v], m_bend), sweep: 1});
        end
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check("code",  bus.o_code,  mon_e.code);
                check("voice", bus.o_voice, mon_e.voice);
                check("sweep", bus.o_sweep, mon_e.sweep);
            end
        end
    end

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(sb.size() == 0 && bus.o_ready) && n < 400);
        check({tag, "_drain"}, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Latency counts cycles after the accept edge up to and including the strobe cycle
    task automatic do_req(input int v, input int n, input int exp_lat);
        int lat;
        int w;
        w = 0;
        while (!bus.o_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        bus.i_req   = 1'b1;
        bus.i_voice = V_W'(v);
        bus.i_note  = 7'(n);
        m_notes[v]  = n;
        sb.push_back('{voice: v, code: model_code(n, m_bend), sweep: 0});
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.o_valid && lat < 40);
        check($sformatf("latency_n%0d", n), lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic bend_write(input int b);
        bus.i_bend_we = 1'b1;
        bus.i_bend    = 14'(b);
        m_bend        = b;
        push_sweep();
        @(posedge clk); #1;
        bus.i_bend_we = 1'b0;
        wait_drain($sformatf("bend%0d", b));
    endtask

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_voice   = '0;
        bus.i_note    = '0;
        bus.i_bend_we = 1'b0;
        bus.i_bend    = 14'd8192;
        m_bend        = 8192;
        for (int i = 0; i < N_V; i++) m_notes[i] = 78;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_code",  bus.o_code,  0);
        check("rst_voice", bus.o_voice, 0);
        check("rst_sweep", bus.o_sweep, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single notes at centre bend, covering octave extremes and a non-zero semitone
        do_req(2, 120, 14);
        do_req(0, 108, 13);
        do_req(1, 60, 9);
        do_req(3, 0, 4);
        do_req(0, 66, 9);
        do_req(1, 127, 14);

        // Bend extremes: each write re-tunes all four voices, then a fresh request
        bend_write(16383);
        do_req(2, 120, 14);
        bend_write(0);
        do_req(2, 120, 14);

        // Two writes while busy collapse into one sweep with the latest bend
        bus.i_req   = 1'b1;
        bus.i_voice = 2'd1;
        bus.i_note  = 7'd127;
        m_notes[1]  = 127;
        m_bend      = 12000;
        sb.push_back('{voice: 1, code: model_code(127, 12000), sweep: 0});
        push_sweep();
        @(posedge clk); #1;
        bus.i_req     = 1'b0;
        bus.i_bend_we = 1'b1;
        bus.i_bend    = 14'd4000;
        @(posedge clk); #1;
        bus.i_bend    = 14'd12000;
        @(posedge clk); #1;
        bus.i_bend_we = 1'b0;
        wait_drain("collapse");

        // Request and pending sweep together: request first, held i_req accepted once
        bus.i_bend_we = 1'b1;
        bus.i_bend    = 14'd8192;
        m_bend        = 8192;
        @(posedge clk); #1;
        bus.i_bend_we = 1'b0;
        bus.i_req     = 1'b1;
        bus.i_voice   = 2'd3;
        bus.i_note    = 7'd60;
        m_notes[3]    = 60;
        sb.push_back('{voice: 3, code: model_code(60, 8192), sweep: 0});
        push_sweep();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_valid && n < 40);
        bus.i_req = 1'b0;
        wait_drain("req_vs_sweep");

        // Asynchronous reset in the middle of a computation
        bus.i_req   = 1'b1;
        bus.i_voice = 2'd0;
        bus.i_note  = 7'd127;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_code",  bus.o_code,  0);
        check("midrst_ready", bus.o_ready, 1);
        sb.delete();
        for (int i = 0; i < N_V; i++) m_notes[i] = 78;
        m_bend = 8192;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bend_write(8192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
